// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry, FSM state and data types.
package regfile_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    typedef enum logic {ARB, INIT} arb_state_e;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] j;
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        // Scan farthest offset first so the candidate closest to ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: round-robin arbitration of the register file write port
// plus an init sweep that writes INIT_VAL to every register.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                      CLK_i,
    input  logic                      RES_i,
    input  logic [NUM_REQ-1:0]        REQ_VALID_i,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_DEST_i,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA_i,
    output logic [NUM_REQ-1:0]        REQ_READY_o,
    input  logic                      INIT_START_i,
    output logic                      INIT_BUSY_o,
    output logic                      WRT_EN_o,
    output logic [ADDR_W-1:0]         WRT_DEST_o,
    output logic [DATA_W-1:0]         WRT_DATA_o,
    output logic [GW-1:0]             GRANT_ID_o
);
    arb_state_e          state;
    logic [GW-1:0]       rr_ptr;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REQ-1:0]  grant;
    logic [GW-1:0]       idx;
    logic                any;
    logic                take;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (REQ_VALID_i),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    assign take        = !RES_i && state == ARB && !INIT_START_i && any;
    assign REQ_READY_o = take ? grant : '0;
    assign INIT_BUSY_o = state == INIT;

    always_ff @(posedge CLK_i) begin
        if (RES_i) begin
            state      <= ARB;
            rr_ptr     <= '0;
            cnt        <= '0;
            WRT_EN_o   <= 1'b0;
            WRT_DEST_o <= '0;
            WRT_DATA_o <= '0;
            GRANT_ID_o <= '0;
        end else if (state == INIT) begin
            // cnt mirrors the address currently presented on the write port.
            if (cnt == '1) begin
                state    <= ARB;
                WRT_EN_o <= 1'b0;
            end else begin
                cnt        <= cnt + 1'b1;
                WRT_EN_o   <= 1'b1;
                WRT_DEST_o <= cnt + 1'b1;
                WRT_DATA_o <= INIT_VAL;
            end
        end else if (INIT_START_i) begin
            state      <= INIT;
            cnt        <= '0;
            WRT_EN_o   <= 1'b1;
            WRT_DEST_o <= '0;
            WRT_DATA_o <= INIT_VAL;
        end else if (take) begin
            WRT_EN_o   <= 1'b1;
            WRT_DEST_o <= REQ_DEST_i[idx*ADDR_W +: ADDR_W];
            WRT_DATA_o <= REQ_DATA_i[idx*DATA_W +: DATA_W];
            GRANT_ID_o <= idx;
            rr_ptr     <= (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end else begin
            WRT_EN_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed scenario tests for regfile_wr_arb.
module tb_regfile_wr_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [11:0] dest;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        start;
    logic        busy;
    logic        wrt_en;
    logic [2:0]  wrt_dest;
    logic [7:0]  wrt_data;
    logic [1:0]  grant_id;
    int          vectors = 0;
    int          errors = 0;

    regfile_wr_arb dut (
        .CLK_i        (clk),
        .RES_i        (rst),
        .REQ_VALID_i  (valid),
        .REQ_DEST_i   (dest),
        .REQ_DATA_i   (data),
        .REQ_READY_o  (ready),
        .INIT_START_i (start),
        .INIT_BUSY_o  (busy),
        .WRT_EN_o     (wrt_en),
        .WRT_DEST_o   (wrt_dest),
        .WRT_DATA_o   (wrt_data),
        .GRANT_ID_o   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] d, input logic [7:0] v);
        dest[k*3 +: 3] = d;
        data[k*8 +: 8] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 4'hF; start = 1'b0; dest = '0; data = '0;
        tick();
        tick();
        vectors++;
        if ({ready, busy, wrt_en, wrt_dest, wrt_data, grant_id} !== 19'd0)
            begin errors++; $display("FAIL reset: got %h want 0", {ready, busy, wrt_en, wrt_dest, wrt_data, grant_id}); end
        rst = 1'b0; valid = 4'h0;
        tick();
    endtask

    task automatic test_init();
        start = 1'b1;
        #1;
        vectors++;
        if (ready !== 4'h0) begin errors++; $display("FAIL init_start_ready: got %b want 0000", ready); end
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // A second start pulse mid-sweep must not restart it.
            start = (i == 4);
            #1;
            vectors++;
            if ({ready, busy, wrt_en, wrt_dest, wrt_data} !== {4'h0, 2'b11, 3'(i), 8'h00})
                begin errors++; $display("FAIL init_sweep[%0d]: got %h want %h", i, {ready, busy, wrt_en, wrt_dest, wrt_data}, {4'h0, 2'b11, 3'(i), 8'h00}); end
            tick();
        end
        start = 1'b0;
        vectors++;
        if ({busy, wrt_en} !== 2'b00) begin errors++; $display("FAIL init_end: got busy/en %b want 00", {busy, wrt_en}); end
    endtask

    task automatic test_single();
        set_req(2, 3'd5, 8'hA5);
        valid = 4'b0100;
        #1;
        vectors++;
        if (ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", ready); end
        tick();
        valid = 4'h0;
        vectors++;
        if ({wrt_en, wrt_dest, wrt_data, grant_id} !== {1'b1, 3'd5, 8'hA5, 2'd2})
            begin errors++; $display("FAIL single_write: got %h want %h", {wrt_en, wrt_dest, wrt_data, grant_id}, {1'b1, 3'd5, 8'hA5, 2'd2}); end
        tick();
        vectors++;
        if ({wrt_en, wrt_dest, wrt_data} !== {1'b0, 3'd5, 8'hA5})
            begin errors++; $display("FAIL idle_hold: got %h want %h", {wrt_en, wrt_dest, wrt_data}, {1'b0, 3'd5, 8'hA5}); end
    endtask

    task automatic test_back_to_back();
        int k;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) set_req(r, 3'(r + 1), 8'(8'h10 + r));
        valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            k = i % 4;
            #1;
            vectors++;
            if (ready !== 4'(1 << k)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready, 4'(1 << k)); end
            tick();
            vectors++;
            if ({wrt_en, wrt_dest, wrt_data, grant_id} !== {1'b1, 3'(k + 1), 8'(8'h10 + k), 2'(k)})
                begin errors++; $display("FAIL b2b_write[%0d]: got %h want %h", i, {wrt_en, wrt_dest, wrt_data, grant_id}, {1'b1, 3'(k + 1), 8'(8'h10 + k), 2'(k)}); end
        end
        valid = 4'h0;
        tick();
    endtask

    task automatic test_rr_ptr();
        valid = 4'b0010;
        tick();
        valid = 4'b1010;
        #1;
        vectors++;
        if (ready !== 4'b1000) begin errors++; $display("FAIL rr_first: got %b want 1000", ready); end
        tick();
        vectors++;
        if ({wrt_en, grant_id, ready} !== {1'b1, 2'd3, 4'b0010})
            begin errors++; $display("FAIL rr_second: got %h want %h", {wrt_en, grant_id, ready}, {1'b1, 2'd3, 4'b0010}); end
        tick();
        valid = 4'h0;
        vectors++;
        if ({wrt_en, grant_id, wrt_dest} !== {1'b1, 2'd1, 3'd2})
            begin errors++; $display("FAIL rr_third: got %h want %h", {wrt_en, grant_id, wrt_dest}, {1'b1, 2'd1, 3'd2}); end
        tick();
    endtask

    task automatic test_init_blocks_requests();
        valid = 4'b0011;
        start = 1'b1;
        #1;
        vectors++;
        if (ready !== 4'h0) begin errors++; $display("FAIL blk_start_ready: got %b want 0000", ready); end
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({ready, busy, wrt_en, wrt_dest} !== {4'h0, 2'b11, 3'(i)})
                begin errors++; $display("FAIL blk_sweep[%0d]: got %h want %h", i, {ready, busy, wrt_en, wrt_dest}, {4'h0, 2'b11, 3'(i)}); end
            tick();
        end
        vectors++;
        if ({busy, wrt_en, ready} !== {2'b00, 4'b0001})
            begin errors++; $display("FAIL blk_resume: got %h want %h", {busy, wrt_en, ready}, {2'b00, 4'b0001}); end
        tick();
        vectors++;
        if ({wrt_en, grant_id, ready} !== {1'b1, 2'd0, 4'b0010})
            begin errors++; $display("FAIL blk_after: got %h want %h", {wrt_en, grant_id, ready}, {1'b1, 2'd0, 4'b0010}); end
        tick();
        valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_during_init();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if ({busy, wrt_en, wrt_dest} !== {2'b11, 3'd3})
            begin errors++; $display("FAIL rst_init_pre: got %h want %h", {busy, wrt_en, wrt_dest}, {2'b11, 3'd3}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, wrt_en, wrt_dest, wrt_data} !== 13'd0)
            begin errors++; $display("FAIL rst_init_post: got %h want 0", {busy, wrt_en, wrt_dest, wrt_data}); end
        set_req(0, 3'd6, 8'h3C);
        set_req(3, 3'd1, 8'hC3);
        valid = 4'b1001;
        #1;
        vectors++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_ready: got %b want 0001", ready); end
        tick();
        valid = 4'h0;
        vectors++;
        if ({wrt_en, grant_id, wrt_dest, wrt_data} !== {1'b1, 2'd0, 3'd6, 8'h3C})
            begin errors++; $display("FAIL rst_ptr_write: got %h want %h", {wrt_en, grant_id, wrt_dest, wrt_data}, {1'b1, 2'd0, 3'd6, 8'h3C}); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_back_to_back();
        test_rr_ptr();
        test_init_blocks_requests();
        test_reset_during_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Write-port arbiter and initialiser for the 8x8 register file.
- Shares the single write port (WRT_EN/WRT_DEST/WRT_DATA) between NUM_REQ requesters using round-robin valid/ready arbitration.
- Provides an init sequencer that writes INIT_VAL to every register on request, for example after boot or on a soft clear.
- Sits between requesters (decode/writeback, debug loader) and the register file write inputs.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- ADDR_W, 3, register address width; the file has 2**ADDR_W entries.
- DATA_W, 8, register data width.
- INIT_VAL, 8'h00, value written to every register during init.

Ports:
- CLK_i  in  1  clock; all logic is rising-edge.
- RES_i  in  1  synchronous active-high reset.
- REQ_VALID_i  in  NUM_REQ  per-requester write request.
- REQ_DEST_i  in  NUM_REQ*ADDR_W  packed destination address; requester k uses slice [k*ADDR_W +: ADDR_W].
- REQ_DATA_i  in  NUM_REQ*DATA_W  packed write data; requester k uses slice [k*DATA_W +: DATA_W].
- REQ_READY_o  out  NUM_REQ  one-hot grant, combinational.
- INIT_START_i  in  1  single-cycle pulse that starts the init sweep.
- INIT_BUSY_o  out  1  high while the init sweep is in progress.
- WRT_EN_o  out  1  register file write enable, registered.
- WRT_DEST_o  out  ADDR_W  register file write address, registered.
- WRT_DATA_o  out  DATA_W  register file write data, registered.
- GRANT_ID_o  out  clog2(NUM_REQ)  index of the requester that produced the current write, registered; only meaningful when WRT_EN_o=1 and INIT_BUSY_o=0.

Behaviour:
- Reset (RES_i=1 at a clock edge):
  - state goes to ARB; rr_ptr=0; init counter=0.
  - WRT_EN_o=0, WRT_DEST_o=0, WRT_DATA_o=0, GRANT_ID_o=0, INIT_BUSY_o=0.
  - REQ_READY_o=0 while RES_i is high.
  - Reset overrides everything, including an init sweep in progress.
- Handshake:
  - A transfer occurs when REQ_VALID_i[k] & REQ_READY_o[k] are both high in the same cycle.
  - A requester holds VALID, DEST and DATA stable until the transfer.
  - READY may depend combinationally on VALID; VALID must never depend on READY.
- State ARB:
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first requester with VALID high gets READY.
  - At most one READY bit is high per cycle.
  - On a transfer from requester k, the next edge sets WRT_EN_o=1, WRT_DEST_o=dest[k], WRT_DATA_o=data[k], GRANT_ID_o=k, and rr_ptr=(k+1) mod NUM_REQ.
  - Write latency is 1 cycle from acceptance.
  - With no request, the next edge sets WRT_EN_o=0; DEST and DATA hold their previous values and rr_ptr is unchanged.
  - Back-to-back grants are allowed, giving one write per cycle of sustained throughput.
- Transition ARB->INIT on INIT_START_i=1:
  - In that cycle all READY bits are 0 and no grant is made.
  - A write already registered from the previous cycle still completes.
  - The next edge enters INIT with the counter at 0, and INIT_BUSY_o=1 from that edge.
- State INIT:
  - All READY bits are 0.
  - Each cycle the registered outputs are WRT_EN_o=1, WRT_DEST_o=counter, WRT_DATA_o=INIT_VAL, then the counter increments.
  - When counter=2**ADDR_W-1 is issued, the next edge returns to ARB with INIT_BUSY_o=0 and WRT_EN_o=0 unless a grant is made in that cycle.
  - The sweep takes exactly 2**ADDR_W cycles of writes.
  - INIT_START_i during INIT is ignored; the sweep does not restart.
  - rr_ptr is preserved across INIT.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,3,0,... and there is no starvation. Worst-case wait is NUM_REQ-1 grants plus any init sweep.
- Same-address collisions between requesters are not merged; the later-granted write wins at the register file.
- Widths: rr_ptr and GRANT_ID_o are clog2(NUM_REQ) bits; the init counter is ADDR_W bits with no extra overflow bit, and the terminal compare is on the all-ones value.

Decomposition:
- Package regfile_pkg holds:
  - ADDR_W=3 and DATA_W=8 as localparams shared with the register file;
  - typedef enum logic {ARB, INIT} arb_state_e;
  - typedef logic [ADDR_W-1:0] reg_addr_t and logic [DATA_W-1:0] reg_data_t.
- Sub-module rr_arbiter:
  - combinational round-robin priority pick;
  - inputs: req vector and rr_ptr; outputs: one-hot grant, grant index, any_grant.
  - Instantiated once.
- The top level holds the FSM, rr_ptr, the init counter and the output registers.

Test Plan:
1. Reset then INIT_START_i pulse -> INIT_BUSY_o high for 8 cycles; WRT_DEST_o=0..7 in order with WRT_DATA_o=8'h00 and WRT_EN_o=1 each cycle; then BUSY=0 and EN=0; all READY=0 throughout.
2. Only requester 2 valid with dest=3'd5, data=8'hA5 -> READY[2]=1 in the same cycle; next cycle EN=1, DEST=5, DATA=A5, GRANT_ID=2.
3. All four valid continuously for 8 cycles -> READY sequence 0,1,2,3,0,1,2,3; EN=1 every cycle, one cycle after each grant.
4. Requesters 1 and 3 valid with rr_ptr=2 -> grant 3 first, then 1.
5. INIT_START_i asserted while requesters 0 and 1 are valid -> no READY that cycle and throughout the 8-cycle sweep; afterwards arbitration resumes from the preserved rr_ptr.
6. RES_i asserted during the 4th init write -> next edge gives BUSY=0, EN=0, rr_ptr=0; after release, a single request to requester 0 is granted immediately.
